// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg
// Shared constants for the multicycle control unit: FSM state encodings,
// RV32I major opcodes, ALU-op / write-back select encodings, immediate-format
// (instruction_type) codes and the instruction class produced by the decoder.
package multicycle_control_unit_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEMORY    = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_TRAP      = 3'd5;

    // RV32I major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // alu_op encodings
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_BRANCH = 2'b10;
    localparam logic [1:0] ALU_PASS_B = 2'b11;

    // wb_sel encodings
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // instruction_type (immediate format) encodings
    localparam logic [2:0] ITYPE_R    = 3'd0;
    localparam logic [2:0] ITYPE_I    = 3'd1;
    localparam logic [2:0] ITYPE_S    = 3'd2;
    localparam logic [2:0] ITYPE_B    = 3'd3;
    localparam logic [2:0] ITYPE_U    = 3'd4;
    localparam logic [2:0] ITYPE_J    = 3'd5;
    localparam logic [2:0] ITYPE_NONE = 3'd7;

    // Instruction class: selects the EXECUTE/MEMORY/WRITEBACK behaviour
    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_BRANCH = 4'd7,
        CLS_OP_IMM = 4'd8,
        CLS_OP     = 4'd9,
        CLS_NOP    = 4'd10
    } instr_class_e;

    // Jumps write PC+4 to rd and take the ALU target as the next PC.
    function automatic logic is_jump(input instr_class_e cls);
        return (cls == CLS_JAL) || (cls == CLS_JALR);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_opcode_decoder.sv
// opcode_decoder
// Purely combinational map from the 7-bit major opcode to the immediate format,
// the instruction class and a legal flag.
// Ports:
//   i_opcode  in  7  instruction[6:0]
//   o_itype   out 3  immediate format (ITYPE_*), ITYPE_NONE when illegal
//   o_class   out 4  instruction class (CLS_*), CLS_NONE when illegal
//   o_legal   out 1  opcode is one of the supported RV32I major opcodes
module opcode_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0]   i_opcode,
    output logic [2:0]   o_itype,
    output instr_class_e o_class,
    output logic         o_legal
);

    always_comb begin
        o_itype = ITYPE_NONE;
        o_class = CLS_NONE;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_LUI:    begin o_itype = ITYPE_U; o_class = CLS_LUI;    end
            OPC_AUIPC:  begin o_itype = ITYPE_U; o_class = CLS_AUIPC;  end
            OPC_JAL:    begin o_itype = ITYPE_J; o_class = CLS_JAL;    end
            OPC_JALR:   begin o_itype = ITYPE_I; o_class = CLS_JALR;   end
            OPC_LOAD:   begin o_itype = ITYPE_I; o_class = CLS_LOAD;   end
            OPC_OP_IMM: begin o_itype = ITYPE_I; o_class = CLS_OP_IMM; end
            OPC_STORE:  begin o_itype = ITYPE_S; o_class = CLS_STORE;  end
            OPC_BRANCH: begin o_itype = ITYPE_B; o_class = CLS_BRANCH; end
            OPC_OP:     begin o_itype = ITYPE_R; o_class = CLS_OP;     end
            // FENCE and SYSTEM only advance the PC in this core.
            OPC_FENCE,
            OPC_SYSTEM: begin o_itype = ITYPE_I; o_class = CLS_NOP;    end
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Control FSM of a multicycle RV32I core: FETCH -> DECODE -> EXECUTE ->
// (MEMORY) -> (WRITEBACK), with a sticky TRAP state for illegal opcodes.
// All strobes are Moore outputs of the state, qualified by mem_ready only in
// FETCH (ir_write) and MEMORY (store pc_write / state advance).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   instruction[31:0]     IR contents, valid from DECODE onward
//   mem_ready             memory read data valid / write accepted
//   branch_taken          branch-compare result, used in EXECUTE
//   mem_valid/mem_we/mem_addr_sel   memory request controls
//   ir_write, pc_write, pc_src      IR / PC update controls
//   alu_src_a, alu_src_b, alu_op    ALU operand and operation selects
//   reg_write, wb_sel               register-file write controls
//   instruction_type[2:0] immediate format for the immediate generator
//   illegal_instruction   sticky trap flag
//   instret[31:0]         retired instruction count (wraps)
//   dbg_state[2:0]        current FSM state (ST_* encoding) for debug
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_valid,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  instruction_type,
    output logic        illegal_instruction,
    output logic [31:0] instret,
    output logic [2:0]  dbg_state
);

    logic [2:0]   r_state;
    logic [31:0]  r_instret;
    logic         r_illegal;

    logic [2:0]   w_next_state;
    logic [2:0]   w_itype;
    instr_class_e w_cls;
    logic         w_legal;

    logic         w_mem_valid;
    logic         w_mem_we;
    logic         w_mem_addr_sel;
    logic         w_ir_write;
    logic         w_pc_write;
    logic         w_pc_src;
    logic         w_alu_src_a;
    logic         w_alu_src_b;
    logic [1:0]   w_alu_op;
    logic         w_reg_write;
    logic [1:0]   w_wb_sel;

    // Only the opcode field steers control; the rest of the IR is consumed
    // by the datapath.
    logic w_unused_ir_bits;
    assign w_unused_ir_bits = ^instruction[31:7];

    opcode_decoder u_opcode_decoder (
        .i_opcode (instruction[6:0]),
        .o_itype  (w_itype),
        .o_class  (w_cls),
        .o_legal  (w_legal)
    );

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:     if (mem_ready) w_next_state = ST_DECODE;
            ST_DECODE:    w_next_state = w_legal ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE: begin
                case (w_cls)
                    CLS_BRANCH, CLS_NOP:  w_next_state = ST_FETCH;
                    CLS_LOAD, CLS_STORE:  w_next_state = ST_MEMORY;
                    default:              w_next_state = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (mem_ready)
                    w_next_state = (w_cls == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
            end
            ST_WRITEBACK: w_next_state = ST_FETCH;
            ST_TRAP:      w_next_state = ST_TRAP;
            default:      w_next_state = ST_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        w_mem_valid    = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src       = 1'b0;
        w_alu_src_a    = 1'b0;
        w_alu_src_b    = 1'b0;
        w_alu_op       = ALU_ADD;
        w_reg_write    = 1'b0;
        w_wb_sel       = WB_ALU;
        case (r_state)
            ST_FETCH: begin
                w_mem_valid = 1'b1;
                w_ir_write  = mem_ready;
            end
            ST_EXECUTE: begin
                case (w_cls)
                    CLS_BRANCH: begin
                        w_alu_op   = ALU_BRANCH;
                        w_pc_write = 1'b1;
                        w_pc_src   = branch_taken;
                    end
                    CLS_LOAD, CLS_STORE, CLS_JALR: begin
                        w_alu_src_b = 1'b1;
                    end
                    CLS_JAL, CLS_AUIPC: begin
                        w_alu_src_a = 1'b1;
                        w_alu_src_b = 1'b1;
                    end
                    CLS_LUI: begin
                        w_alu_op    = ALU_PASS_B;
                        w_alu_src_b = 1'b1;
                    end
                    CLS_OP_IMM: begin
                        w_alu_op    = ALU_FUNCT;
                        w_alu_src_b = 1'b1;
                    end
                    CLS_OP: begin
                        w_alu_op    = ALU_FUNCT;
                    end
                    CLS_NOP: begin
                        w_pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEMORY: begin
                // Request controls depend only on state and class so they
                // stay constant for the whole wait.
                w_mem_valid    = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (w_cls == CLS_STORE);
                w_pc_write     = (w_cls == CLS_STORE) && mem_ready;
            end
            ST_WRITEBACK: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_pc_src    = is_jump(w_cls);
                if (is_jump(w_cls))
                    w_wb_sel = WB_PC4;
                else if (w_cls == CLS_LOAD)
                    w_wb_sel = WB_MEM;
                else
                    w_wb_sel = WB_ALU;
            end
            default: ;
        endcase
        // The state register only changes at the edge, so strobes must be
        // suppressed combinationally while reset is held.
        if (reset) begin
            w_mem_valid    = 1'b0;
            w_mem_we       = 1'b0;
            w_mem_addr_sel = 1'b0;
            w_ir_write     = 1'b0;
            w_pc_write     = 1'b0;
            w_reg_write    = 1'b0;
        end
    end

    // Every instruction ends with exactly one pc_write, so it doubles as the
    // retire pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_instret <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_write)
                r_instret <= r_instret + 32'd1;
            if (r_state == ST_DECODE && !w_legal)
                r_illegal <= 1'b1;
        end
    end

    assign mem_valid           = w_mem_valid;
    assign mem_we              = w_mem_we;
    assign mem_addr_sel        = w_mem_addr_sel;
    assign ir_write            = w_ir_write;
    assign pc_write            = w_pc_write;
    assign pc_src              = w_pc_src;
    assign alu_src_a           = w_alu_src_a;
    assign alu_src_b           = w_alu_src_b;
    assign alu_op              = w_alu_op;
    assign reg_write           = w_reg_write;
    assign wb_sel              = w_wb_sel;
    assign instruction_type    = w_itype;
    assign illegal_instruction = r_illegal;
    assign instret             = r_instret;
    assign dbg_state           = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A per-instruction model
// expands each instruction into the cycle-by-cycle output vectors the control
// unit must produce; a compare process checks the DUT against them on every
// falling edge. Directed literal checks pin retire counts, memory-wait length,
// trap behaviour and reset.
module tb_multicycle_control_unit;

    localparam int W = 49;

    // Immediate-format codes as seen on instruction_type
    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_NONE = 3'd7;

    typedef enum int {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_STORE,
                      K_BRANCH, K_OPIMM, K_OP, K_NOP, K_ILL} kind_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] instruction = 32'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_valid, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic        alu_src_a, alu_src_b, reg_write, illegal_instruction;
    logic [1:0]  alu_op, wb_sel;
    logic [2:0]  instruction_type, dbg_state;
    logic [31:0] instret;

    multicycle_control_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction         (instruction),
        .mem_ready           (mem_ready),
        .branch_taken        (branch_taken),
        .mem_valid           (mem_valid),
        .mem_we              (mem_we),
        .mem_addr_sel        (mem_addr_sel),
        .ir_write            (ir_write),
        .pc_write            (pc_write),
        .pc_src              (pc_src),
        .alu_src_a           (alu_src_a),
        .alu_src_b           (alu_src_b),
        .alu_op              (alu_op),
        .reg_write           (reg_write),
        .wb_sel              (wb_sel),
        .instruction_type    (instruction_type),
        .illegal_instruction (illegal_instruction),
        .instret             (instret),
        .dbg_state           (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] m_instret = 32'd0;
    int          data_cycles = 0;   // DUT cycles with a data-side request

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic mv, we, as, irw, pcw, pcs, sa, sb,
                                        input logic [1:0] aop, input logic rw,
                                        input logic [1:0] wb, input logic [2:0] ty,
                                        input logic ill, input logic [31:0] ir);
        return {mv, we, as, irw, pcw, pcs, sa, sb, aop, rw, wb, ty, ill, ir};
    endfunction

    logic [W-1:0] cmp_got, cmp_exp;
    always @(negedge clk) begin
        if (!reset && mem_valid && mem_addr_sel) data_cycles++;
        if (exp_q.size() > 0) begin
            cmp_exp = exp_q.pop_front();
            cmp_got = {mem_valid, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                       alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
                       instruction_type, illegal_instruction, instret};
            check("ctrl", {47'd0, cmp_got[48:32]}, {47'd0, cmp_exp[48:32]});
            check("instret", {32'd0, cmp_got[31:0]}, {32'd0, cmp_exp[31:0]});
        end
    end

    // ---------------- model ----------------
    function automatic kind_t classify(input logic [6:0] op);
        case (op)
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BRANCH;
            7'b0010011: return K_OPIMM;
            7'b0110011: return K_OP;
            7'b0001111, 7'b1110011: return K_NOP;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] fmt(input kind_t k);
        case (k)
            K_LUI, K_AUIPC: return T_U;
            K_JAL:          return T_J;
            K_JALR, K_LOAD, K_OPIMM, K_NOP: return T_I;
            K_STORE:        return T_S;
            K_BRANCH:       return T_B;
            K_OP:           return T_R;
            default:        return T_NONE;
        endcase
    endfunction

    // Outputs of the execute step: operand/operation selects per instruction kind.
    function automatic logic [W-1:0] exec_vec(input kind_t k, input logic bt, input logic [31:0] ir);
        logic pcw, pcs, sa, sb;
        logic [1:0] aop;
        pcw = 1'b0; pcs = 1'b0; sa = 1'b0; sb = 1'b0; aop = 2'b00;
        case (k)
            K_BRANCH:            begin aop = 2'b10; pcw = 1'b1; pcs = bt; end
            K_LOAD, K_STORE:     sb = 1'b1;
            K_JAL, K_AUIPC:      begin sa = 1'b1; sb = 1'b1; end
            K_JALR:              sb = 1'b1;
            K_LUI:               begin aop = 2'b11; sb = 1'b1; end
            K_OPIMM:             begin aop = 2'b01; sb = 1'b1; end
            K_OP:                aop = 2'b01;
            K_NOP:               pcw = 1'b1;
            default: ;
        endcase
        return mk(0, 0, 0, 0, pcw, pcs, sa, sb, aop, 0, 2'b00, fmt(k), 0, ir);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic [W-1:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction through the unit. fdelay/mdelay are the number of
    // not-ready cycles before mem_ready on fetch/data access. mem_abort >= 0
    // stops after that many data-wait cycles, leaving the unit mid-MEMORY.
    task automatic run_instr(input logic [31:0] instr, input int fdelay, input int mdelay,
                             input logic bt, input int mem_abort);
        kind_t      k;
        logic [2:0] ty;
        logic       st, jmp;
        k  = classify(instr[6:0]);
        ty = fmt(k);
        st = (k == K_STORE);
        jmp = (k == K_JAL) || (k == K_JALR);
        instruction  = instr;
        branch_taken = bt;
        for (int i = 0; i <= fdelay; i++) begin
            mem_ready = (i == fdelay);
            step(mk(1, 0, 0, mem_ready, 0, 0, 0, 0, 2'b00, 0, 2'b00, ty, 0, m_instret));
        end
        mem_ready = 1'($urandom_range(0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, ty, 0, m_instret));
        if (k == K_ILL) return;
        mem_ready = 1'($urandom_range(0, 1));
        step(exec_vec(k, bt, m_instret));
        if (k == K_BRANCH || k == K_NOP) begin
            m_instret++;
            return;
        end
        if (k == K_LOAD || st) begin
            for (int j = 0; j <= mdelay; j++) begin
                if (mem_abort >= 0 && j == mem_abort) return;
                mem_ready = (j == mdelay);
                step(mk(1, st, 1, 0, st & mem_ready, 0, 0, 0, 2'b00, 0, 2'b00, ty, 0, m_instret));
            end
            if (st) begin
                m_instret++;
                return;
            end
        end
        mem_ready = 1'($urandom_range(0, 1));
        step(mk(0, 0, 0, 0, 1, jmp, 0, 0, 2'b00, 1,
                jmp ? 2'b10 : (k == K_LOAD ? 2'b01 : 2'b00), ty, 0, m_instret));
        m_instret++;
    endtask

    // Holds reset for n cycles; during each reset cycle no strobe may fire.
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_strobes", {59'd0, mem_valid, ir_write, pc_write, reg_write, mem_we}, 64'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        m_instret = 32'd0;
    endtask

    // Directed check of the first post-reset cycle while fetch is not yet ready.
    task automatic first_fetch_check(input string name);
        mem_ready = 1'b0;
        @(negedge clk);
        check({name, "_mem_valid"}, {63'd0, mem_valid}, 64'd1);
        check({name, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        check({name, "_instret"}, {32'd0, instret}, 64'd0);
        check({name, "_illegal"}, {63'd0, illegal_instruction}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] prog [9];
    logic [2:0]  trap_state;

    initial begin
        prog[0] = 32'h123450B7;  // LUI
        prog[1] = 32'h00001097;  // AUIPC
        prog[2] = 32'h008000EF;  // JAL
        prog[3] = 32'h000080E7;  // JALR
        prog[4] = 32'h002081B3;  // ADD
        prog[5] = 32'h0000000F;  // FENCE
        prog[6] = 32'h00000073;  // ECALL
        prog[7] = 32'h0000A103;  // LW
        prog[8] = 32'h0020A023;  // SW

        do_reset(2);
        first_fetch_check("post_reset");

        // ADDI: FETCH, DECODE, EXECUTE, WRITEBACK then one retire
        run_instr(32'h00500093, 0, 0, 1'b0, -1);
        check("addi_instret", {32'd0, instret}, 64'd1);

        // LW with three not-ready data cycles: four cycles of data request
        data_cycles = 0;
        run_instr(32'h0000A103, 1, 3, 1'b0, -1);
        check("lw_instret", {32'd0, instret}, 64'd2);
        check("lw_data_cycles", 64'(data_cycles), 64'd4);

        // BEQ taken and not taken
        run_instr(32'h00000463, 0, 0, 1'b1, -1);
        check("beq_t_instret", {32'd0, instret}, 64'd3);
        run_instr(32'h00000463, 2, 0, 1'b0, -1);
        check("beq_nt_instret", {32'd0, instret}, 64'd4);

        // SW, ready immediately
        data_cycles = 0;
        run_instr(32'h0020A023, 0, 0, 1'b0, -1);
        check("sw_instret", {32'd0, instret}, 64'd5);
        check("sw_data_cycles", 64'(data_cycles), 64'd1);

        // Remaining instruction kinds with assorted memory latencies
        foreach (prog[i])
            run_instr(prog[i], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), -1);
        check("mix_instret", {32'd0, instret}, 64'd14);

        // SW interrupted by reset during its data wait
        run_instr(32'h0020A023, 0, 5, 1'b0, 2);
        do_reset(1);
        first_fetch_check("sw_abort");
        run_instr(32'h00500093, 0, 0, 1'b0, -1);
        check("after_abort_instret", {32'd0, instret}, 64'd1);

        // Illegal opcode: trap, ten quiet cycles, then reset clears it
        run_instr(32'h00000000, 0, 0, 1'b0, -1);
        @(negedge clk);
        trap_state = dbg_state;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, T_NONE, 1, m_instret));
        end
        @(negedge clk);
        check("trap_illegal", {63'd0, illegal_instruction}, 64'd1);
        check("trap_state_hold", {61'd0, dbg_state}, {61'd0, trap_state});
        @(posedge clk);
        #1;
        do_reset(1);
        first_fetch_check("trap_reset");
        run_instr(32'h00000463, 0, 0, 1'b1, -1);
        check("after_trap_instret", {32'd0, instret}, 64'd1);

        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 One clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 instruction  input  32  current IR contents; valid from DECODE onward.
REQ-005 mem_ready  input  1  memory done; read data valid or write accepted this cycle.
REQ-006 branch_taken  input  1  ALU branch-compare result, sampled in EXECUTE.
REQ-007 mem_valid  output  1  memory request strobe.
REQ-008 mem_we  output  1  1 = store, 0 = read.
REQ-009 mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result (data).
REQ-010 ir_write  output  1  load IR from memory read data.
REQ-011 pc_write  output  1  update PC.
REQ-012 pc_src  output  1  0 = PC+4, 1 = ALU target.
REQ-013 alu_src_a  output  1  0 = rs1, 1 = PC.
REQ-014 alu_src_b  output  1  0 = rs2, 1 = immediate.
REQ-015 alu_op  output  2  00 ADD, 01 FUNCT (use funct3/funct7), 10 BRANCH compare, 11 PASS_B.
REQ-016 reg_write  output  1  register-file write enable.
REQ-017 wb_sel  output  2  00 ALU, 01 memory data, 10 PC+4.
REQ-018 instruction_type  output  3  drives the immediate generator; encodings come from Defines.vh.
REQ-019 illegal_instruction  output  1  sticky trap flag.
REQ-020 instret  output  32  count of retired instructions.

Function
REQ-021 FSM states SHALL be FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
REQ-022 FETCH: mem_valid=1, mem_addr_sel=0, mem_we=0. Stay in FETCH until mem_ready. On mem_ready, ir_write=1 and go to DECODE.
REQ-023 DECODE: instruction_type SHALL be decoded from opcode[6:0]:
- 0110111 / 0010111 -> U
- 1101111 -> J
- 1100111 / 0000011 / 0010011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110011 -> R
- 0001111 / 1110011 -> I (executed as NOP)
REQ-024 DECODE with any other opcode SHALL go to TRAP. Otherwise go to EXECUTE.
REQ-025 EXECUTE, branch: alu_op=BRANCH, pc_write=1, pc_src=branch_taken; retire; go to FETCH.
REQ-026 EXECUTE, load/store: alu_op=ADD, src_b=imm; go to MEMORY.
REQ-027 EXECUTE, JAL/AUIPC: src_a=PC, src_b=imm, ADD.
REQ-028 EXECUTE, JALR: src_a=rs1, src_b=imm, ADD.
REQ-029 EXECUTE, LUI: PASS_B with imm.
REQ-030 EXECUTE, OP/OP-IMM: FUNCT, src_b = imm for OP-IMM, rs2 for OP. All of REQ-027 to REQ-030 go to WRITEBACK.
REQ-031 EXECUTE, FENCE/SYSTEM: pc_write=1, pc_src=0; retire; go to FETCH.
REQ-032 MEMORY: mem_valid=1, mem_addr_sel=1, mem_we=store. Hold until mem_ready, then a store sets pc_write=1, pc_src=0, retires and goes to FETCH; a load goes to WRITEBACK.
REQ-033 WRITEBACK: reg_write=1, pc_write=1, pc_src=1 for JAL/JALR else 0, and wb_sel as follows:
- 10 for JAL/JALR
- 01 for load
- 00 otherwise
Retire, then go to FETCH.
REQ-034 mem_valid, mem_we and mem_addr_sel SHALL stay constant while waiting for mem_ready. There is no timeout.
REQ-035 Every strobe (pc_write, ir_write, reg_write, mem_valid) SHALL be a Moore function of state plus the REQ-022/REQ-032 mem_ready qualification. Exactly one pc_write pulse per instruction.
REQ-036 instret SHALL increment by 1 in the cycle of the final pc_write of each instruction. It wraps from 0xFFFFFFFF to 0.
REQ-037 TRAP: all strobes 0, illegal_instruction=1. Stay in TRAP until reset.
REQ-038 Latency with mem_ready asserted immediately:
- branch/FENCE/SYSTEM: 3 cycles
- ALU/jump/LUI/AUIPC: 4 cycles
- store: 4 cycles
- load: 5 cycles

Reset
REQ-039 reset SHALL force state=FETCH, instret=0 and illegal_instruction=0, from any state including a mid-MEMORY wait or TRAP.
REQ-040 During a reset cycle all strobes SHALL be 0. The first cycle after reset is FETCH with mem_valid=1.

Structure
REQ-041 Opcode values, state encodings, alu_op/wb_sel encodings and instruction_type values SHALL live in the shared Defines.vh.
REQ-042 One combinational sub-module, opcode_decoder, SHALL map opcode to instruction_type, an instruction class and a legal flag. The FSM, the instret counter and the output logic SHALL be in multicycle_control_unit.

Verification
REQ-043 ADDI 0x00500093, mem_ready tied to 1: sequence FETCH, DECODE, EXECUTE, WRITEBACK; reg_write=1 in cycle 4; instret=1 after cycle 4.
REQ-044 LW 0x0000A103, data mem_ready delayed 3 cycles: MEMORY held 4 cycles with mem_addr_sel=1 and mem_we=0 stable; then WRITEBACK with wb_sel=01.
REQ-045 BEQ 0x00000463: with branch_taken=1, EXECUTE has pc_write=1 and pc_src=1; with branch_taken=0, pc_src=0; neither case passes through WRITEBACK.
REQ-046 Opcode 0x00000000: DECODE goes to TRAP, illegal_instruction=1 held for 10 cycles with no strobes; a reset pulse returns to FETCH with the flag cleared.
REQ-047 SW 0x0020A023 with reset asserted during the MEMORY wait: next cycle FETCH, instret=0, mem_we=0.
